// File: rtl/rlc_pio_capture.sv
// Parametrised debounced PIO with per-bit edge capture, edge polarity, IRQ mask
// and atomic output set/clear, behind a single Avalon-MM slave.
module rlc_pio_capture #(
    parameter int unsigned          WIDTH           = 16,
    parameter int unsigned          DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0]     OUT_RESET       = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [WIDTH-1:0] avs_writedata,
    output logic [WIDTH-1:0] avs_readdata,
    input  logic [WIDTH-1:0] pio_in_export,
    output logic [WIDTH-1:0] pio_out_export,
    output logic             irq
);

    typedef enum logic [1:0] {
        ST_HOLD0,
        ST_HOLD1,
        ST_HOLD2,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_edge_en;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] w_deb_next;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_next;
    logic [WIDTH-1:0] r_mode;
    logic [WIDTH-1:0] w_mode_next;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_cap_next;
    logic [WIDTH-1:0] w_cap_clr;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_hit;

    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] w_rdata;
    logic             r_irq;

    // Two-flop synchroniser for the asynchronous inputs.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pio_in_export;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign w_deb_next = r_sync2;
        end else begin : g_deb
            localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt      [WIDTH];
            logic [CNT_W-1:0] w_cnt_next [WIDTH];

            // A bit is accepted once sync has differed from deb for DEBOUNCE_CYCLES cycles.
            always_comb begin
                w_deb_next = r_deb;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_cnt_next[i] = '0;
                    if (r_sync2[i] != r_deb[i]) begin
                        if (r_cnt[i] == CNT_LAST) begin
                            w_deb_next[i] = r_sync2[i];
                        end else begin
                            w_cnt_next[i] = r_cnt[i] + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    endgenerate

    // Post-reset edge suppression sequencer.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= ST_HOLD0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HOLD0: w_state_next = ST_HOLD1;
            ST_HOLD1: w_state_next = ST_HOLD2;
            ST_HOLD2: w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_HOLD0;
        endcase
    end

    always_comb begin
        w_edge_en = (r_state == ST_RUN);
    end

    assign w_rise     = w_deb_next & ~r_deb;
    assign w_fall     = ~w_deb_next & r_deb;
    assign w_edge_hit = w_edge_en ? ((r_mode & w_fall) | (~r_mode & w_rise)) : '0;

    // Register writes; clear-then-set ordering lets a new edge win over W1C.
    always_comb begin
        w_out_next  = r_out;
        w_mask_next = r_mask;
        w_mode_next = r_mode;
        w_cap_clr   = '0;
        if (avs_write) begin
            case (avs_address)
                3'd0:    w_out_next  = avs_writedata;
                3'd1:    w_out_next  = r_out | avs_writedata;
                3'd2:    w_out_next  = r_out & ~avs_writedata;
                3'd3:    w_mask_next = avs_writedata;
                3'd4:    w_cap_clr   = avs_writedata;
                3'd5:    w_mode_next = avs_writedata;
                default: ;
            endcase
        end
        w_cap_next = (r_cap & ~w_cap_clr) | w_edge_hit;
    end

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            3'd0:    w_rdata = r_deb;
            3'd3:    w_rdata = r_mask;
            3'd4:    w_rdata = r_cap;
            3'd5:    w_rdata = r_mode;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_deb   <= '0;
            r_out   <= OUT_RESET;
            r_mask  <= '0;
            r_mode  <= '0;
            r_cap   <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_deb  <= w_deb_next;
            r_out  <= w_out_next;
            r_mask <= w_mask_next;
            r_mode <= w_mode_next;
            r_cap  <= w_cap_next;
            r_irq  <= |(w_cap_next & w_mask_next);
            if (avs_read) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign avs_readdata   = r_rdata;
    assign pio_out_export = r_out;
    assign irq            = r_irq;

endmodule

// File: tb/tb_rlc_pio_capture.sv
// Directed bench for rlc_pio_capture: vector table for register behaviour plus
// hand-written sequences for debounce timing, W1C/set collision and mid-run reset.
module tb_rlc_pio_capture;

    logic        clk;
    logic        rst;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic [15:0] pio_in;
    logic [15:0] pio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    rlc_pio_capture #(
        .WIDTH           (16),
        .DEBOUNCE_CYCLES (4),
        .OUT_RESET       (16'h00A5)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .pio_in_export  (pio_in),
        .pio_out_export (pio_out),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] pin;
        int          settle;
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic [15:0] exp_out;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, sampled at the following posedge.
    task automatic access(input logic wr, input logic rd, input logic [2:0] addr, input logic [15:0] wd);
        @(negedge clk);
        avs_write     = wr;
        avs_read      = rd;
        avs_address   = addr;
        avs_writedata = wd;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    function automatic vec_t mk(input logic [15:0] pin, input int settle, input logic wr, input logic rd,
                                input logic [2:0] addr, input logic [15:0] wd, input logic chk_rd,
                                input logic [15:0] exp_rd, input logic [15:0] exp_out, input logic exp_irq);
        vec_t v;
        v.pin = pin; v.settle = settle; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wd;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_irq = exp_irq;
        return v;
    endfunction

    initial begin
        //                pin      settle wr rd addr wdata     chk rd_exp    out_exp   irq
        vecs.push_back(mk(16'h0000, 0, 1, 0, 3'd0, 16'h1234, 0, 16'h0000, 16'h1234, 0));
        vecs.push_back(mk(16'h0F0F, 8, 0, 1, 3'd0, 16'h0000, 1, 16'h0F0F, 16'h1234, 0));
        vecs.push_back(mk(16'h0F0F, 0, 0, 1, 3'd4, 16'h0000, 1, 16'h0F0F, 16'h1234, 0));
        vecs.push_back(mk(16'h0F0F, 0, 1, 0, 3'd4, 16'hFFFF, 0, 16'h0000, 16'h1234, 0));
        vecs.push_back(mk(16'h0F0F, 0, 0, 1, 3'd4, 16'h0000, 1, 16'h0000, 16'h1234, 0));
        vecs.push_back(mk(16'h0F0F, 0, 1, 0, 3'd0, 16'h00F0, 0, 16'h0000, 16'h00F0, 0));
        vecs.push_back(mk(16'h0F0F, 0, 1, 0, 3'd1, 16'h0003, 0, 16'h0000, 16'h00F3, 0));
        vecs.push_back(mk(16'h0F0F, 0, 1, 0, 3'd2, 16'h0030, 0, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0F, 0, 0, 1, 3'd1, 16'h0000, 1, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0F, 0, 0, 1, 3'd2, 16'h0000, 1, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0F, 0, 1, 0, 3'd7, 16'hFFFF, 0, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0F, 0, 0, 1, 3'd6, 16'h0000, 1, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0C, 8, 0, 1, 3'd4, 16'h0000, 1, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0C, 0, 1, 0, 3'd5, 16'h0002, 0, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0C, 0, 0, 1, 3'd5, 16'h0000, 1, 16'h0002, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0C, 0, 1, 0, 3'd3, 16'h0003, 0, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0C, 0, 0, 1, 3'd3, 16'h0000, 1, 16'h0003, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0F, 8, 0, 1, 3'd4, 16'h0000, 1, 16'h0001, 16'h00C3, 1));
        vecs.push_back(mk(16'h0F0D, 8, 0, 1, 3'd4, 16'h0000, 1, 16'h0003, 16'h00C3, 1));
        vecs.push_back(mk(16'h0F0D, 0, 1, 0, 3'd4, 16'h0003, 0, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0D, 0, 0, 1, 3'd4, 16'h0000, 1, 16'h0000, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0D, 0, 1, 1, 3'd3, 16'h0005, 1, 16'h0003, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0D, 0, 0, 1, 3'd3, 16'h0000, 1, 16'h0005, 16'h00C3, 0));
        vecs.push_back(mk(16'h0F0D, 0, 0, 1, 3'd0, 16'h0000, 1, 16'h0F0D, 16'h00C3, 0));

        // Reset state
        rst = 1'b1; pio_in = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_address = '0; avs_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", pio_out, 16'h00A5);
        check("reset_rdata", avs_readdata, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) begin
            @(negedge clk);
            pio_in = vecs[n].pin;
            repeat (vecs[n].settle) @(posedge clk);
            access(vecs[n].wr, vecs[n].rd, vecs[n].addr, vecs[n].wdata);
            if (vecs[n].chk_rd)
                check($sformatf("vec%0d_rdata", n), avs_readdata, vecs[n].exp_rd);
            check($sformatf("vec%0d_out", n), pio_out, vecs[n].exp_out);
            check($sformatf("vec%0d_irq", n), {15'b0, irq}, {15'b0, vecs[n].exp_irq});
        end

        // Debounce: short glitch on bit0 rejected, mask=0005 mode=0002 here
        @(negedge clk); pio_in = 16'h0F0C;
        repeat (8) @(posedge clk);
        @(negedge clk); pio_in = 16'h0F0D;
        repeat (3) @(posedge clk);
        @(negedge clk); pio_in = 16'h0F0C;
        repeat (8) @(posedge clk);
        access(1'b0, 1'b1, 3'd0, '0);
        check("glitch_data", avs_readdata, 16'h0F0C);
        access(1'b0, 1'b1, 3'd4, '0);
        check("glitch_cap", avs_readdata, 16'h0000);
        check("glitch_irq", {15'b0, irq}, 16'h0000);

        // Held change: deb updates on the 6th edge, so read at edge k shows it from k=6
        @(negedge clk);
        pio_in = 16'h0F0D; avs_read = 1'b1; avs_address = 3'd0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_bit0_k%0d", k), {15'b0, avs_readdata[0]}, {15'b0, (k >= 6) ? 1'b1 : 1'b0});
            check($sformatf("hold_irq_k%0d", k), {15'b0, irq}, {15'b0, (k >= 5) ? 1'b1 : 1'b0});
        end
        @(negedge clk); avs_read = 1'b0;

        // W1C of bit0 coinciding with a new bit0 rising edge: set wins
        @(negedge clk); pio_in = 16'h0F0C;
        repeat (8) @(posedge clk);
        @(negedge clk); pio_in = 16'h0F0D;
        repeat (5) @(posedge clk);
        access(1'b1, 1'b0, 3'd4, 16'h0001);
        check("collide_irq", {15'b0, irq}, 16'h0001);
        access(1'b0, 1'b1, 3'd4, '0);
        check("collide_cap", avs_readdata, 16'h0001);
        check("collide_irq2", {15'b0, irq}, 16'h0001);
        access(1'b1, 1'b0, 3'd4, 16'h0001);
        check("clr_irq", {15'b0, irq}, 16'h0000);

        // Reset mid-debounce with EDGECAP=0005
        @(negedge clk); pio_in = 16'h0F08;
        repeat (8) @(posedge clk);
        @(negedge clk); pio_in = 16'h0F0D;
        repeat (8) @(posedge clk);
        access(1'b0, 1'b1, 3'd4, '0);
        check("pre_rst_cap", avs_readdata, 16'h0005);
        check("pre_rst_irq", {15'b0, irq}, 16'h0001);
        @(negedge clk); pio_in = 16'h0F08;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_out", pio_out, 16'h00A5);
        check("mid_rst_irq", {15'b0, irq}, 16'h0000);
        check("mid_rst_rdata", avs_readdata, 16'h0000);
        @(negedge clk);
        rst = 1'b0; avs_read = 1'b1; avs_address = 3'd4;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_cap_k%0d", k), avs_readdata, 16'h0000);
            check($sformatf("post_rst_irq_k%0d", k), {15'b0, irq}, 16'h0000);
        end
        @(negedge clk); avs_address = 3'd3;
        @(posedge clk); #1;
        check("post_rst_mask", avs_readdata, 16'h0000);
        @(negedge clk); avs_address = 3'd0;
        @(posedge clk); #1;
        check("post_rst_data", avs_readdata, 16'h0000);
        @(negedge clk); avs_read = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
